// File: rtl/pause_sequencer_pkg.sv
// Shared definitions for the pause sequencer slice.
//   state_t          : sequencer states (STEP exists only with PAUSE_SEQ_STEP_EN)
//   OPT_PAUSE_OSD    : options bit, pause while the OSD is open
//   OPT_DIM          : options bit, enable burn-in dimming
//   DEF_*            : default sizing / timing constants
// Build macro: PAUSE_SEQ_STEP_EN adds the single-frame STEP state.
package pause_pkg;

  localparam int unsigned OPT_PAUSE_OSD = 0;
  localparam int unsigned OPT_DIM       = 1;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_CLKSPD     = 12;
  // Cycles per MHz of clk_sys: 10 s dim delay, 20 ms vblank timeout.
  localparam int unsigned DEF_DIM_PER_MHZ = 10_000_000;
  localparam int unsigned DEF_VB_PER_MHZ  = 20_000;

`ifdef PAUSE_SEQ_STEP_EN
  typedef enum logic [2:0] {
    RUN,
    WAIT_ENTER,
    PAUSED,
    WAIT_EXIT,
    STEP
  } state_t;
`else
  typedef enum logic [1:0] {
    RUN,
    WAIT_ENTER,
    PAUSED,
    WAIT_EXIT
  } state_t;
`endif

endpackage

// File: rtl/pause_sequencer_edge.sv
// Registered rising-edge detector.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   sig     : level input (already synchronous to clk_sys)
//   rise    : high for the cycle in which sig is 1 and was 0 the cycle before
module pause_edge (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pause_sequencer.sv
// Central pause controller. Arbitrates core requesters, the user pause button
// and the OSD, aligns CPU halt entry/exit to vblank (with a timeout), grants
// requesters once the CPU is halted and runs the burn-in dim timer.
//   clk_sys, reset_n     : clock, asynchronous active-low reset
//   cpu_reset            : core CPU reset, forces RUN and clears the user toggle
//   req[NREQ]/grant[NREQ]: per-requester pause request / halted acknowledge
//   user_button          : user pause toggle button (synchronised)
//   osd_status, options  : OSD open; [0] pause while OSD open, [1] dim enable
//   vblank               : vertical blank from video timing
//   pause_cpu, paused    : CPU halt, state==PAUSED (registered)
//   dim_video            : halve RGB after the dim delay (registered)
//   pause_src            : active sources {osd, user, req} (registered)
//   frame_step           : only with PAUSE_SEQ_STEP_EN, runs one frame from PAUSED
module pause_sequencer
  import pause_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned CLKSPD     = DEF_CLKSPD,
  parameter int unsigned DIM_CYCLES = CLKSPD * DEF_DIM_PER_MHZ,
  parameter int unsigned VB_TIMEOUT = CLKSPD * DEF_VB_PER_MHZ
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            cpu_reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  input  logic            user_button,
  input  logic            osd_status,
  input  logic [1:0]      options,
  input  logic            vblank,
`ifdef PAUSE_SEQ_STEP_EN
  input  logic            frame_step,
`endif
  output logic            pause_cpu,
  output logic            paused,
  output logic            dim_video,
  output logic [NREQ+1:0] pause_src
);

  localparam int unsigned WCW = (VB_TIMEOUT > 1) ? $clog2(VB_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(VB_TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [31:0]    dim_cnt, dim_nxt;
  logic           user_tog, user_tog_nxt;
  logic           vb_rise, ub_rise;
  logic           any, vb_ok, waiting, dim_run;

  pause_edge u_vb_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .sig     (vblank),
    .rise    (vb_rise)
  );

  pause_edge u_ub_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .sig     (user_button),
    .rise    (ub_rise)
  );

`ifdef PAUSE_SEQ_STEP_EN
  logic fs_rise;

  pause_edge u_fs_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .sig     (frame_step),
    .rise    (fs_rise)
  );
`endif

  always_comb begin
    any = ((|req) | user_tog | (osd_status & options[OPT_PAUSE_OSD])) & ~cpu_reset;
    vb_ok = vb_rise | (wait_cnt == WAIT_LAST);
    user_tog_nxt = cpu_reset ? 1'b0 : (user_tog ^ ub_rise);

    state_nxt = state;
    if (cpu_reset) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:        if (any) state_nxt = WAIT_ENTER;
        // Demand is checked before the boundary so a same-cycle drop aborts.
        WAIT_ENTER: if (!any) state_nxt = RUN;
                    else if (vb_ok) state_nxt = PAUSED;
        PAUSED: begin
          if (!any) state_nxt = WAIT_EXIT;
`ifdef PAUSE_SEQ_STEP_EN
          else if (fs_rise) state_nxt = STEP;
`endif
        end
        WAIT_EXIT:  if (any) state_nxt = PAUSED;
                    else if (vb_ok) state_nxt = RUN;
`ifdef PAUSE_SEQ_STEP_EN
        STEP:       if (vb_ok) state_nxt = any ? PAUSED : RUN;
`endif
        default:    state_nxt = RUN;
      endcase
    end

    waiting = (state == WAIT_ENTER) || (state == WAIT_EXIT);
`ifdef PAUSE_SEQ_STEP_EN
    waiting = waiting || (state == STEP);
`endif
    if (state_nxt != state)            wait_nxt = '0;
    else if (waiting && wait_cnt != '1) wait_nxt = wait_cnt + 1'b1;
    else                               wait_nxt = wait_cnt;

    // Count only while staying in PAUSED, so every (re)entry starts from zero
    // and the first WAIT_EXIT/STEP cycle already shows dim_video low.
    dim_run = (state_nxt == PAUSED) && (state == PAUSED) && options[OPT_DIM];
    if (!dim_run)                  dim_nxt = '0;
    else if (dim_cnt == DIM_CYCLES) dim_nxt = dim_cnt;
    else                           dim_nxt = dim_cnt + 32'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      dim_cnt   <= '0;
      user_tog  <= 1'b0;
      pause_cpu <= 1'b0;
      paused    <= 1'b0;
      dim_video <= 1'b0;
      grant     <= '0;
      pause_src <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      dim_cnt   <= dim_nxt;
      user_tog  <= user_tog_nxt;
      pause_cpu <= (state_nxt == PAUSED) || (state_nxt == WAIT_EXIT);
      paused    <= (state_nxt == PAUSED);
      dim_video <= dim_run && (dim_nxt == DIM_CYCLES);
      // Grant only when the CPU has been halted for a full cycle and stays so;
      // this delays grants one cycle past halt entry and drops them with any
      // exit, so a grant is never seen while pause_cpu is low.
      grant     <= ((state_nxt == PAUSED) && (state == PAUSED)) ? req : '0;
      pause_src <= cpu_reset ? '0
                 : {osd_status & options[OPT_PAUSE_OSD], user_tog, req};
    end
  end

endmodule
